// File: rtl/arbiter_vc_if.sv
// Bundle of the two VC FIFO heads, downstream pause and merged output for arbiter_vc.
// The master side feeds the FIFO heads; the slave side is the arbiter.
interface arbiter_vc_if #(
    parameter int BITNUMBER = 6
);
    logic [BITNUMBER-1:0] vc0_data;
    logic                 vc0_empty;
    logic [BITNUMBER-1:0] vc1_data;
    logic                 vc1_empty;
    logic                 out_pause;
    logic                 vc0_pop;
    logic                 vc1_pop;
    logic [BITNUMBER-1:0] arb_data_out;
    logic                 arb_wr;
    logic                 arb_last_vc;

    modport master (
        output vc0_data, vc0_empty, vc1_data, vc1_empty, out_pause,
        input  vc0_pop, vc1_pop, arb_data_out, arb_wr, arb_last_vc
    );

    modport slave (
        input  vc0_data, vc0_empty, vc1_data, vc1_empty, out_pause,
        output vc0_pop, vc1_pop, arb_data_out, arb_wr, arb_last_vc
    );
endinterface

// File: rtl/arbiter_vc.sv
// Two-VC merge arbiter: pops one FWFT head per cycle and registers it for the downstream FIFO.
// Define ARB_RR_EN for round-robin between VCs; otherwise VC0 has strict priority.
module arbiter_vc #(
    parameter int BITNUMBER = 6
) (
    input  logic        clk,
    input  logic        reset,
    arbiter_vc_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LAST0 = 2'd1,
        LAST1 = 2'd2
    } state_e;

    state_e               state_q;
    logic                 wr_q;
    logic [BITNUMBER-1:0] data_q;
    logic [BITNUMBER-1:0] data_d;
    logic                 grant0;
    logic                 grant1;
    logic                 prefer1;

`ifdef ARB_RR_EN
    assign prefer1 = (state_q == LAST0);
`else
    assign prefer1 = 1'b0;
`endif

    // Pops are held off while reset is low so neither FIFO loses a word.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (reset && !bus.out_pause) begin
            if (!bus.vc0_empty && (bus.vc1_empty || !prefer1)) begin
                grant0 = 1'b1;
            end else if (!bus.vc1_empty) begin
                grant1 = 1'b1;
            end
        end
    end

    assign data_d = grant1 ? bus.vc1_data : bus.vc0_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            wr_q <= grant0 | grant1;
            if (grant0 || grant1) begin
                data_q  <= data_d;
                state_q <= grant1 ? LAST1 : LAST0;
            end
        end
    end

    assign bus.vc0_pop      = grant0;
    assign bus.vc1_pop      = grant1;
    assign bus.arb_wr       = wr_q;
    assign bus.arb_data_out = data_q;
    // The state register already records the VC of the last forwarded word.
    assign bus.arb_last_vc  = (state_q == LAST1);

endmodule

// File: tb/tb_arbiter_vc.sv
// Directed and stream tests for arbiter_vc; expectations follow the build's ARB_RR_EN setting.
module tb_arbiter_vc;
    localparam int BW = 6;
`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    arbiter_vc_if #(.BITNUMBER(BW)) bus();

    arbiter_vc #(.BITNUMBER(BW)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    typedef struct {
        logic       r;
        logic       e0;
        logic [5:0] d0;
        logic       e1;
        logic [5:0] d1;
        logic       p;
        logic [1:0] pops;
        logic       wr;
        logic [5:0] dat;
        logic       last;
    } vec_t;

    vec_t       vecs[$];
    logic [5:0] src0[$];
    logic [5:0] src1[$];
    logic [5:0] ref0[$];
    logic [5:0] ref1[$];
    logic [5:0] got[$];
    logic [4:0] seq0 = '0;
    logic [4:0] seq1 = '0;
    logic [5:0] exp35[6];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic e0, input logic [5:0] d0,
                       input logic e1, input logic [5:0] d1, input logic p,
                       input logic [1:0] pops, input logic wr, input logic [5:0] dat,
                       input logic last);
        vec_t v;
        v.r = r; v.e0 = e0; v.d0 = d0; v.e1 = e1; v.d1 = d1; v.p = p;
        v.pops = pops; v.wr = wr; v.dat = dat; v.last = last;
        vecs.push_back(v);
    endtask

    task automatic stream(input int cycles, input bit rnd);
        logic p0;
        logic p1;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (rnd) begin
                if ($urandom_range(0, 2) == 0) begin
                    src0.push_back({1'b0, seq0});
                    ref0.push_back({1'b0, seq0});
                    seq0++;
                end
                if ($urandom_range(0, 2) == 0) begin
                    src1.push_back({1'b1, seq1});
                    ref1.push_back({1'b1, seq1});
                    seq1++;
                end
                bus.out_pause = ($urandom_range(0, 3) == 0);
            end else begin
                bus.out_pause = 1'b0;
            end
            bus.vc0_empty = (src0.size() == 0);
            bus.vc0_data  = (src0.size() == 0) ? 6'h3F : src0[0];
            bus.vc1_empty = (src1.size() == 0);
            bus.vc1_data  = (src1.size() == 0) ? 6'h3F : src1[0];
            #1;
            p0 = bus.vc0_pop;
            p1 = bus.vc1_pop;
            chk("pop_legal", 16'({p0 & p1, p0 & bus.vc0_empty, p1 & bus.vc1_empty,
                                   (p0 | p1) & bus.out_pause}), 16'h0000);
            if (bus.arb_wr) begin
                got.push_back(bus.arb_data_out);
                if (!bus.arb_last_vc) begin
                    if (ref0.size() == 0) chk("vc0_extra", 16'(bus.arb_data_out), 16'hFFFF);
                    else chk("vc0_order", 16'(bus.arb_data_out), 16'(ref0.pop_front()));
                end else begin
                    if (ref1.size() == 0) chk("vc1_extra", 16'(bus.arb_data_out), 16'hFFFF);
                    else chk("vc1_order", 16'(bus.arb_data_out), 16'(ref1.pop_front()));
                end
            end
            @(posedge clk);
            if (p0 && src0.size() != 0) void'(src0.pop_front());
            if (p1 && src1.size() != 0) void'(src1.pop_front());
        end
    endtask

    initial begin
        bus.vc0_data  = '0;
        bus.vc0_empty = 1'b1;
        bus.vc1_data  = '0;
        bus.vc1_empty = 1'b1;
        bus.out_pause = 1'b0;

        //   r  e0 d0     e1 d1     p  pops   wr dat    last
        add(0, 0, 6'h3F, 0, 6'h2A, 0, 2'b00, 0, 6'h00, 0);
        add(1, 0, 6'h05, 1, 6'h2A, 0, 2'b10, 0, 6'h00, 0);
        add(1, 0, 6'h0A, 1, 6'h2A, 0, 2'b10, 1, 6'h05, 0);
        add(1, 1, 6'h0A, 1, 6'h2A, 0, 2'b00, 1, 6'h0A, 0);
        add(1, 1, 6'h0A, 1, 6'h2A, 0, 2'b00, 0, 6'h0A, 0);
        add(1, 1, 6'h0A, 0, 6'h21, 0, 2'b01, 0, 6'h0A, 0);
        add(1, 0, 6'h11, 0, 6'h22, 0, 2'b10, 1, 6'h21, 1);
        add(1, 0, 6'h12, 0, 6'h22, 1, 2'b00, 1, 6'h11, 0);
        add(1, 0, 6'h12, 0, 6'h22, 1, 2'b00, 0, 6'h11, 0);
        add(1, 0, 6'h12, 0, 6'h22, 1, 2'b00, 0, 6'h11, 0);
        add(1, 1, 6'h12, 0, 6'h22, 0, 2'b01, 0, 6'h11, 0);
        add(1, 0, 6'h12, 1, 6'h22, 0, 2'b10, 1, 6'h22, 1);
        add(1, 0, 6'h14, 0, 6'h24, 0, RR ? 2'b01 : 2'b10, 1, 6'h12, 0);
        add(1, 0, 6'h15, 0, 6'h25, 1, 2'b00, 1, RR ? 6'h24 : 6'h14, RR);
        add(0, 0, 6'h15, 0, 6'h25, 0, 2'b00, 0, 6'h00, 0);
        add(1, 0, 6'h13, 0, 6'h23, 0, 2'b10, 0, 6'h00, 0);
        add(1, 1, 6'h13, 1, 6'h23, 0, 2'b00, 1, 6'h13, 0);
        add(1, 1, 6'h13, 1, 6'h23, 0, 2'b00, 0, 6'h13, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst           = vecs[i].r;
            bus.vc0_empty = vecs[i].e0;
            bus.vc0_data  = vecs[i].d0;
            bus.vc1_empty = vecs[i].e1;
            bus.vc1_data  = vecs[i].d1;
            bus.out_pause = vecs[i].p;
            #1;
            chk($sformatf("vec%0d_pops", i), 16'({bus.vc0_pop, bus.vc1_pop}), 16'(vecs[i].pops));
            chk($sformatf("vec%0d_out", i),
                16'({bus.arb_wr, bus.arb_data_out, bus.arb_last_vc}),
                16'({vecs[i].wr, vecs[i].dat, vecs[i].last}));
        end

        // Reset in the cycle after 6'h07 is popped: the word must vanish.
        @(negedge clk);
        bus.vc0_empty = 1'b0;
        bus.vc0_data  = 6'h07;
        bus.vc1_empty = 1'b1;
        bus.out_pause = 1'b0;
        #1;
        chk("r07_pop", 16'(bus.vc0_pop), 16'h0001);
        @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.vc0_empty = 1'b1;
        #1;
        chk("r07_reset", 16'({bus.arb_wr, bus.arb_data_out}), 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("r07_no_wr", 16'({bus.arb_wr, bus.arb_data_out}), 16'h0000);
        end

        // Three words per VC, no pause: full-rate merge in arbitration order.
        src0 = '{6'h01, 6'h02, 6'h03};
        ref0 = '{6'h01, 6'h02, 6'h03};
        src1 = '{6'h21, 6'h22, 6'h23};
        ref1 = '{6'h21, 6'h22, 6'h23};
        if (RR) exp35 = '{6'h01, 6'h21, 6'h02, 6'h22, 6'h03, 6'h23};
        else    exp35 = '{6'h01, 6'h02, 6'h03, 6'h21, 6'h22, 6'h23};
        got.delete();
        stream(7, 1'b0);
        chk("merge_count", 16'(got.size()), 16'd6);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("merge_word%0d", k),
                16'((k < got.size()) ? got[k] : 6'h3F), 16'(exp35[k]));
        end
        stream(2, 1'b0);
        chk("merge_no_extra", 16'(got.size()), 16'd6);

        // Randomized traffic with random pauses, then drain.
        src0.delete(); src1.delete(); ref0.delete(); ref1.delete();
        stream(200, 1'b1);
        stream(150, 1'b0);
        chk("rand_vc0_drained", 16'(ref0.size()), 16'd0);
        chk("rand_vc1_drained", 16'(ref1.size()), 16'd0);
        chk("rand_fifos_empty", 16'(src0.size() + src1.size()), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
